// File: rtl/sram_arbiter_if.sv
// Bus bundle for the SRAM arbiter: CPU request port, loader port and SRAM pins.
// slave is the arbiter's view; master is the view of the requesters and SRAM.
interface sram_arbiter_if;
    logic        cpu_req;
    logic        cpu_rnw;
    logic [17:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_done;
    logic        cpu_ovf;
    logic        ld_req;
    logic [17:0] ld_addr;
    logic [7:0]  ld_din;
    logic        ld_ack;
    logic        ram_cs_b;
    logic        ram_oe_b;
    logic        ram_we_b;
    logic [17:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_dout_en;
    logic [7:0]  ram_din;
    logic        busy;

    modport slave (
        input  cpu_req, cpu_rnw, cpu_addr, cpu_din, ld_req, ld_addr, ld_din, ram_din,
        output cpu_dout, cpu_done, cpu_ovf, ld_ack, ram_cs_b, ram_oe_b, ram_we_b,
               ram_a, ram_dout, ram_dout_en, busy
    );

    modport master (
        output cpu_req, cpu_rnw, cpu_addr, cpu_din, ld_req, ld_addr, ld_din, ram_din,
        input  cpu_dout, cpu_done, cpu_ovf, ld_ack, ram_cs_b, ram_oe_b, ram_we_b,
               ram_a, ram_dout, ram_dout_en, busy
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-master asynchronous SRAM arbiter: CPU (strict priority, one-deep pending slot)
// and a level-request loader. All SRAM strobes come straight from flops.
module sram_arbiter #(
    parameter int unsigned WE_CYCLES = 3,
    parameter int unsigned RD_CYCLES = 2
) (
    input logic           clk,
    input logic           reset_n,
    sram_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_WSETUP  = 3'd2,
        ST_WSTROBE = 3'd3,
        ST_WHOLD   = 3'd4
    } state_t;

    localparam logic [3:0] RD_LAST = 4'(RD_CYCLES - 1);
    localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        grant_cpu_s, grant_ld_s, acc_end_s;
    logic        sel_rnw_s;
    logic [17:0] sel_addr_s;
    logic [7:0]  sel_din_s;
    logic        pend_r, pend_rnw_r;
    logic [17:0] pend_addr_r;
    logic [7:0]  pend_din_r;
    logic        own_cpu_r;
    logic        cs_b_s, oe_b_s, we_b_s, dout_en_s;
    logic        cs_b_r, oe_b_r, we_b_r, dout_en_r, busy_r;
    logic [17:0] ram_a_r;
    logic [7:0]  ram_dout_r, cpu_dout_r;
    logic        cpu_done_r, ld_ack_r, ovf_r;

    // CPU request source: a pending request is always older than a fresh pulse
    always_comb begin
        if (pend_r) begin
            sel_rnw_s  = pend_rnw_r;
            sel_addr_s = pend_addr_r;
            sel_din_s  = pend_din_r;
        end else begin
            sel_rnw_s  = bus.cpu_rnw;
            sel_addr_s = bus.cpu_addr;
            sel_din_s  = bus.cpu_din;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic: grants happen only from IDLE, so a started write always finishes
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        grant_cpu_s = 1'b0;
        grant_ld_s  = 1'b0;
        acc_end_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.cpu_req || pend_r) begin
                    grant_cpu_s = 1'b1;
                    if (sel_rnw_s) begin
                        state_s = ST_RD;
                        cnt_s   = RD_LAST;
                    end else begin
                        state_s = ST_WSETUP;
                        cnt_s   = 4'd0;
                    end
                end else if (bus.ld_req) begin
                    grant_ld_s = 1'b1;
                    state_s    = ST_WSETUP;
                    cnt_s      = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (cnt_r == 4'd0) begin
                    state_s   = ST_IDLE;
                    acc_end_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_WSETUP: begin
                state_s = ST_WSTROBE;
                cnt_s   = WE_LAST;
            end
            ST_WSTROBE: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_WHOLD;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_WHOLD: begin
                state_s   = ST_IDLE;
                acc_end_s = 1'b1;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Strobe decode from the next state so the registered pins track state_r exactly
    always_comb begin
        cs_b_s    = 1'b1;
        oe_b_s    = 1'b1;
        we_b_s    = 1'b1;
        dout_en_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                cs_b_s = 1'b1;
            end
            ST_RD: begin
                cs_b_s = 1'b0;
                oe_b_s = 1'b0;
            end
            ST_WSETUP, ST_WHOLD: begin
                cs_b_s    = 1'b0;
                dout_en_s = 1'b1;
            end
            ST_WSTROBE: begin
                cs_b_s    = 1'b0;
                we_b_s    = 1'b0;
                dout_en_s = 1'b1;
            end
            default: begin
                cs_b_s = 1'b1;
            end
        endcase
    end

    // Output, bus and completion registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_b_r     <= 1'b1;
            oe_b_r     <= 1'b1;
            we_b_r     <= 1'b1;
            dout_en_r  <= 1'b0;
            busy_r     <= 1'b0;
            ram_a_r    <= 18'd0;
            ram_dout_r <= 8'd0;
            cpu_dout_r <= 8'd0;
            cpu_done_r <= 1'b0;
            ld_ack_r   <= 1'b0;
            own_cpu_r  <= 1'b0;
        end else begin
            cs_b_r     <= cs_b_s;
            oe_b_r     <= oe_b_s;
            we_b_r     <= we_b_s;
            dout_en_r  <= dout_en_s;
            busy_r     <= (state_s != ST_IDLE);
            cpu_done_r <= acc_end_s && own_cpu_r;
            ld_ack_r   <= acc_end_s && !own_cpu_r;
            if (grant_cpu_s) begin
                ram_a_r    <= sel_addr_s;
                ram_dout_r <= sel_din_s;
                own_cpu_r  <= 1'b1;
            end else if (grant_ld_s) begin
                ram_a_r    <= bus.ld_addr;
                ram_dout_r <= bus.ld_din;
                own_cpu_r  <= 1'b0;
            end
            if (state_r == ST_RD && cnt_r == 4'd0) begin
                cpu_dout_r <= bus.ram_din;
            end
        end
    end

    // Pending slot: fresh pulses park here unless granted directly from an empty IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_r      <= 1'b0;
            pend_rnw_r  <= 1'b0;
            pend_addr_r <= 18'd0;
            pend_din_r  <= 8'd0;
            ovf_r       <= 1'b0;
        end else if (bus.cpu_req) begin
            if (state_r != ST_IDLE && pend_r) begin
                ovf_r <= 1'b1;
            end else if (state_r != ST_IDLE || pend_r) begin
                pend_r      <= 1'b1;
                pend_rnw_r  <= bus.cpu_rnw;
                pend_addr_r <= bus.cpu_addr;
                pend_din_r  <= bus.cpu_din;
            end
        end else if (state_r == ST_IDLE && pend_r) begin
            pend_r <= 1'b0;
        end
    end

    assign bus.ram_cs_b    = cs_b_r;
    assign bus.ram_oe_b    = oe_b_r;
    assign bus.ram_we_b    = we_b_r;
    assign bus.ram_dout_en = dout_en_r;
    assign bus.ram_a       = ram_a_r;
    assign bus.ram_dout    = ram_dout_r;
    assign bus.cpu_dout    = cpu_dout_r;
    assign bus.cpu_done    = cpu_done_r;
    assign bus.ld_ack      = ld_ack_r;
    assign bus.cpu_ovf     = ovf_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed scoreboard bench for sram_arbiter (WE_CYCLES=3, RD_CYCLES=2).
// Stimulus pushes hand-computed completions; a monitor checks each cpu_done/ld_ack.
module tb_sram_arbiter;
    typedef struct {
        int          kind;      // 0 cpu read, 1 cpu write, 2 loader write
        logic [17:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_dout;
        int          issue;
        int          lat;
        int          cs_len;
        int          oe_len;
        int          we_len;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    exp_t sb_q[$];

    sram_arbiter_if b ();

    sram_arbiter #(.WE_CYCLES(3), .RD_CYCLES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end else begin
            passes = passes + 1;
        end
    endtask

    task automatic push(input int kind, input logic [17:0] addr, input logic [7:0] wdata,
                        input logic [7:0] dout, input int lat, input int cs_len,
                        input int oe_len, input int we_len);
        exp_t e;
        e.kind = kind; e.addr = addr; e.wdata = wdata; e.exp_dout = dout;
        e.issue = cyc; e.lat = lat; e.cs_len = cs_len; e.oe_len = oe_len; e.we_len = we_len;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_pulse(input logic rnw, input logic [17:0] addr, input logic [7:0] din);
        b.cpu_req = 1'b1; b.cpu_rnw = rnw; b.cpu_addr = addr; b.cpu_din = din;
        tick(1);
        b.cpu_req = 1'b0;
    endtask

    task automatic ld_wait_ack();
        int n = 0;
        while (!b.ld_ack && n < 80) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("ld_ack_timeout", int'(n < 80), 1);
        b.ld_req = 1'b0;
        tick(1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb_q.size() != 0 || b.busy) && n < 60) begin
            tick(1);
            n = n + 1;
        end
        chk("drain_timeout", int'(n < 60), 1);
        tick(2);
    endtask

    // Monitor: pops one expectation per completion pulse and checks bus history
    initial begin
        int   cs_n = 0, oe_n = 0, we_n = 0, ovl = 0;
        int   got_src, exp_src;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cs_n = 0; oe_n = 0; we_n = 0; ovl = 0;
            end else begin
                if (b.cpu_done || b.ld_ack) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_done", int'({b.cpu_done, b.ld_ack}), 0);
                    end else begin
                        e = sb_q.pop_front();
                        got_src = int'({b.cpu_done, b.ld_ack});
                        exp_src = (e.kind == 2) ? 1 : 2;
                        chk("done_source", got_src, exp_src);
                        chk("latency", cyc - e.issue, e.lat);
                        chk("cpu_dout", int'(b.cpu_dout), int'(e.exp_dout));
                        chk("ram_a", int'(b.ram_a), int'(e.addr));
                        if (e.kind != 0) chk("ram_dout", int'(b.ram_dout), int'(e.wdata));
                        chk("cs_low_cycles", cs_n, e.cs_len);
                        chk("oe_low_cycles", oe_n, e.oe_len);
                        chk("we_low_cycles", we_n, e.we_len);
                        chk("oe_we_overlap", ovl, 0);
                    end
                    cs_n = 0; oe_n = 0; we_n = 0; ovl = 0;
                end
                if (!b.ram_cs_b) cs_n = cs_n + 1;
                if (!b.ram_oe_b) oe_n = oe_n + 1;
                if (!b.ram_we_b) we_n = we_n + 1;
                if (!b.ram_oe_b && !b.ram_we_b) ovl = 1;
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        b.cpu_req = 1'b0; b.cpu_rnw = 1'b0; b.cpu_addr = 18'd0; b.cpu_din = 8'd0;
        b.ld_req = 1'b0; b.ld_addr = 18'd0; b.ld_din = 8'd0; b.ram_din = 8'd0;
        tick(2);
        chk("rst_cs_b", int'(b.ram_cs_b), 1);
        chk("rst_oe_b", int'(b.ram_oe_b), 1);
        chk("rst_we_b", int'(b.ram_we_b), 1);
        chk("rst_dout_en", int'(b.ram_dout_en), 0);
        chk("rst_ram_a", int'(b.ram_a), 0);
        chk("rst_cpu_dout", int'(b.cpu_dout), 0);
        chk("rst_flags", int'({b.cpu_done, b.ld_ack, b.cpu_ovf, b.busy}), 0);
        reset_n = 1'b1;
        tick(2);

        // CPU read: oe low 2 cycles, done in the 3rd cycle
        b.ram_din = 8'hA5;
        push(0, 18'h0C123, 8'h00, 8'hA5, 3, 2, 2, 0);
        cpu_pulse(1'b1, 18'h0C123, 8'h00);
        wait_drain();

        // CPU write: cs low 5, we low 3, done one cycle after WHOLD
        push(1, 18'h00010, 8'h3C, 8'hA5, 6, 5, 0, 3);
        cpu_pulse(1'b0, 18'h00010, 8'h3C);
        wait_drain();

        // Loader and CPU in the same IDLE cycle: CPU first
        b.ram_din = 8'h5E;
        b.ld_req = 1'b1; b.ld_addr = 18'h3FFFF; b.ld_din = 8'hC3;
        push(0, 18'h00200, 8'h00, 8'h5E, 3, 2, 2, 0);
        push(2, 18'h3FFFF, 8'hC3, 8'h5E, 9, 5, 0, 3);
        cpu_pulse(1'b1, 18'h00200, 8'h00);
        ld_wait_ack();
        wait_drain();

        // CPU request during loader WSTROBE: granted in the ld_ack cycle
        b.ld_req = 1'b1; b.ld_addr = 18'h2A5A5; b.ld_din = 8'h96;
        push(2, 18'h2A5A5, 8'h96, 8'h5E, 6, 5, 0, 3);
        tick(3);
        push(1, 18'h00ABC, 8'h11, 8'h5E, 9, 5, 0, 3);
        cpu_pulse(1'b0, 18'h00ABC, 8'h11);
        ld_wait_ack();
        wait_drain();

        // Three requests during one write: first pends, others dropped, ovf sticky
        b.ram_din = 8'h3E;
        push(1, 18'h30000, 8'hF0, 8'h5E, 6, 5, 0, 3);
        cpu_pulse(1'b0, 18'h30000, 8'hF0);
        push(0, 18'h00777, 8'h00, 8'h3E, 8, 2, 2, 0);
        cpu_pulse(1'b1, 18'h00777, 8'h00);
        chk("ovf_before_drop", int'(b.cpu_ovf), 0);
        tick(1);
        cpu_pulse(1'b0, 18'h01111, 8'h22);
        chk("ovf_set", int'(b.cpu_ovf), 1);
        tick(1);
        cpu_pulse(1'b0, 18'h02222, 8'h44);
        wait_drain();
        chk("ovf_sticky", int'(b.cpu_ovf), 1);

        // Reset in the middle of a loader WSTROBE: immediate release, no ack
        b.ld_req = 1'b1; b.ld_addr = 18'h15555; b.ld_din = 8'h77;
        tick(3);
        chk("we_low_before_reset", int'(b.ram_we_b), 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_we_b", int'(b.ram_we_b), 1);
        chk("abort_cs_b", int'(b.ram_cs_b), 1);
        chk("abort_dout_en", int'(b.ram_dout_en), 0);
        chk("abort_ram_a", int'(b.ram_a), 0);
        chk("abort_cpu_dout", int'(b.cpu_dout), 0);
        chk("abort_flags", int'({b.cpu_done, b.ld_ack, b.cpu_ovf, b.busy}), 0);
        b.ld_req = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(6);
        chk("post_reset_idle", int'({b.busy, b.ram_cs_b}), 1);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WE_CYCLES, default 3, number of clk cycles ram_we_b is held low per write (legal range 1..15).
REQ-002 SHALL have parameter RD_CYCLES, default 2, number of clk cycles ram_oe_b is held low per read (legal range 1..15).
REQ-003 SHALL have port clk  in  1  single clock (100MHz domain), all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port cpu_req  in  1  one-cycle pulse requesting a CPU access.
REQ-006 SHALL have port cpu_rnw  in  1  1=read, 0=write, sampled with cpu_req.
REQ-007 SHALL have port cpu_addr  in  18  CPU address, sampled with cpu_req.
REQ-008 SHALL have port cpu_din  in  8  CPU write data, sampled with cpu_req.
REQ-009 SHALL have port cpu_dout  out  8  last CPU read data.
REQ-010 SHALL have port cpu_done  out  1  one-cycle pulse: CPU access complete.
REQ-011 SHALL have port cpu_ovf  out  1  sticky: cpu_req lost.
REQ-012 SHALL have port ld_req  in  1  level: loader write pending.
REQ-013 SHALL have port ld_addr  in  18  loader address, held stable while ld_req high.
REQ-014 SHALL have port ld_din  in  8  loader write data, held stable while ld_req high.
REQ-015 SHALL have port ld_ack  out  1  one-cycle pulse: loader write complete.
REQ-016 SHALL have ports ram_cs_b, ram_oe_b, ram_we_b  out  1 each  active-low SRAM strobes.
REQ-017 SHALL have ports ram_a  out  18, ram_dout  out  8, ram_dout_en  out  1, ram_din  in  8  SRAM address/data bus.
REQ-018 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, RD, WSETUP, WSTROBE, WHOLD.
REQ-020 SHALL latch cpu_req (with rnw/addr/din) into a one-deep pending slot in any state; the slot clears when granted.
REQ-021 SHALL, in IDLE, grant CPU if cpu_req is high this cycle or the slot is pending; else grant loader if ld_req is high; else remain IDLE.
REQ-022 SHALL give CPU strict priority; a loader write, once granted, SHALL complete uninterrupted.
REQ-023 SHALL set cpu_ovf when cpu_req arrives while the slot is already pending; the new request is dropped, the pending one is kept.
REQ-024 SHALL, on CPU read grant, enter RD for RD_CYCLES cycles with ram_oe_b=0, capture ram_din into cpu_dout on the last RD edge, then return to IDLE.
REQ-025 SHALL, on any write grant, drive ram_a/ram_dout with ram_dout_en=1 through WSETUP (1 cycle, we_b=1), WSTROBE (WE_CYCLES cycles, we_b=0), WHOLD (1 cycle, we_b=1), then return to IDLE.
REQ-026 SHALL hold ram_cs_b=0 in every non-IDLE state, ram_oe_b=0 only in RD, ram_dout_en=1 only in write states; ram_we_b and ram_oe_b SHALL never be low together.
REQ-027 SHALL pulse cpu_done (or ld_ack) for exactly one cycle, the first IDLE cycle after the access; a new grant may occur in that same cycle.
REQ-028 SHALL hold cpu_dout unchanged by writes and loader accesses.
REQ-029 SHALL bound CPU latency (cpu_req to cpu_done) to WE_CYCLES+3 plus own access length.
REQ-030 SHALL hold all counters at widths sufficient for 15 with no wrap during an access.

Reset
REQ-031 SHALL, on reset_n low, immediately force IDLE, ram_cs_b=ram_oe_b=ram_we_b=1, ram_dout_en=0, ram_a=0, ram_dout=0, cpu_dout=0, cpu_done=ld_ack=cpu_ovf=busy=0, pending slot empty.
REQ-032 SHALL abort any access in progress on reset with no ack/done issued.

Verification
REQ-033 SHALL cover: CPU read addr 0x0C123, ram_din=0xA5, RD_CYCLES=2 -> oe_b low 2 cycles, cpu_done in 3rd cycle, cpu_dout=0xA5.
REQ-034 SHALL cover: CPU write 0x00010<-0x3C, WE_CYCLES=3 -> cs_b low 5 cycles, we_b low cycles 2-4, cpu_done next cycle.
REQ-035 SHALL cover: ld_req and cpu_req same IDLE cycle -> CPU served first, ld_ack after following loader write.
REQ-036 SHALL cover: cpu_req during loader WSTROBE -> loader completes, CPU granted in the ld_ack cycle.
REQ-037 SHALL cover: three cpu_req pulses during one write -> one pending, cpu_ovf=1 and sticky.
REQ-038 SHALL cover: reset_n low mid-WSTROBE -> we_b=1, cs_b=1 asynchronously, no ld_ack.
